sqrt_share_scheduler: RTL
=========================

// Module: sqrt_share_scheduler
// PURPOSE
//  Shares one sqrt unit (start/Done/invalid handshake) among N_REQ requesters.
//  Round-robin arbitration; latches the winner's operand; pulses sq_start.
//  Waits for Done/invalid with a watchdog, then returns result/status to the winner.
//  Sits between client blocks and the sqrt controller+datapath pair.
// PARAMETERS
//  N_REQ    4    number of requesters (2..8)
//  DATA_W   16   operand width
//  RES_W    8    result width
//  TIMEOUT  255  max WAIT cycles before abort (1..2^CNT_W-1, CNT_W=8)
// PORTS
//  clock        in   1             clock, rising edge
//  rst          in   1             reset, asynchronous, active-high
//  req          in   N_REQ         level request per client
//  req_data     in   N_REQ*DATA_W  operands; client i at [i*DATA_W +: DATA_W]
//  grant        out  N_REQ         one-hot owner, held START..RESP
//  rsp_valid    out  N_REQ         one-cycle response pulse to owner
//  rsp_result   out  RES_W         result, valid with rsp_valid
//  rsp_invalid  out  1             sqrt unit flagged invalid operand
//  rsp_err      out  1             watchdog timeout
//  busy         out  1             high in every state except IDLE
//  sq_start     out  1             start pulse to sqrt unit
//  sq_operand   out  DATA_W        registered operand, stable START..RESP
//  sq_rst       out  1             one-cycle recovery reset to sqrt unit
//  sq_done      in   1             sqrt Done (1 cycle)
//  sq_invalid   in   1             sqrt invalid (1 cycle)
//  sq_result    in   RES_W         sqrt result
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0, wd_cnt=0; every output and every latch = 0.
//  FSM:
//  - IDLE: any req -> START. On that edge: winner = first set bit scanning rr_ptr,
//    rr_ptr+1, ... (mod N_REQ). Latch owner index and sq_operand.
//  - START: grant=onehot(owner); sq_start=1 for exactly this one cycle -> WAIT.
//  - WAIT: wd_cnt increments each cycle.
//    - sq_invalid -> RESP with invalid=1.
//    - else sq_done -> RESP with result latched from sq_result.
//    - else wd_cnt==TIMEOUT-1 -> ABORT.
//  - ABORT: sq_rst=1 for one cycle; latch err=1 -> RESP.
//  - RESP: rsp_valid[owner]=1 one cycle; rsp_result/invalid/err driven from latches.
//    -> IDLE; rr_ptr=owner+1 (wraps to 0 after N_REQ-1); wd_cnt cleared.
//  Simultaneous and edge-case events:
//  - sq_done and sq_invalid together: invalid wins, rsp_result=0.
//  - Done/invalid on the same edge the watchdog would expire: completion wins, err=0.
//  - sq_done/sq_invalid outside WAIT: ignored.
//  - req dropped mid-job: job still completes and rsp_valid still pulses.
//  Client contract:
//  - A client holds req_data stable until its own grant is seen.
//  - req still high after RESP re-competes at lowest priority.
//  Timing:
//  - Latency: req at IDLE edge k -> sq_start in cycle k+1; RESP one cycle after
//    completion; at least one IDLE cycle between jobs.
//  - Reset mid-operation: immediate return to reset values. A pending sq_start is
//    never emitted; the sqrt unit shares rst.
//  Outputs are registered (sq_start, grant and rsp_* decode from state + latches only).
// STRUCTURE
//  Package sqrt_sched_pkg: state enum {IDLE,START,WAIT,ABORT,RESP},
//    CNT_W, default N_REQ/DATA_W/RES_W.
//  Sub-module rr_arbiter #(N_REQ): combinational req + ptr -> onehot winner, index,
//    any. Pointer register stays in this module.
// TESTING (bench uses a behavioural sqrt model honouring start/Done/invalid)
//  1. N=4, only req[2]=1, data=144, model Done after 10 cycles, result 12
//     -> sq_start 1 cycle after req, sq_operand=144, grant=0100 START..RESP,
//        rsp_valid=0100 for 1 cycle, rsp_result=12, invalid=0, err=0.
//  2. req=1111 held from reset -> grant order 0001,0010,0100,1000,0001;
//     exactly one sq_start per job.
//  3. req[1], model pulses sq_invalid -> rsp_valid=0010, rsp_invalid=1, rsp_result=0.
//  4. TIMEOUT=20, model silent -> 20 WAIT cycles, sq_rst pulse 1 cycle, rsp_err=1,
//     then IDLE and busy=0.
//  5. sq_done on the exact expiry edge -> rsp_err=0, result passed, no sq_rst.
//  6. rst asserted during WAIT of client 3 -> outputs 0 asynchronously, no rsp_valid.
//     After release, req=1001 -> client 0 granted first (rr_ptr=0).

Source files
------------

// File: rtl/sqrt_sched_pkg.sv
// Shared types and defaults for the sqrt unit sharing scheduler.
package sqrt_sched_pkg;

  localparam int unsigned CNT_W      = 8;
  localparam int unsigned DEF_N_REQ  = 4;
  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_RES_W  = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT,
    ABORT,
    RESP
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational winner search from a registered pointer.
// The pointer moves to one past the last served client when advance is high.
module rr_arbiter #(
  parameter  int unsigned N_REQ = 4,
  localparam int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic             clock,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             advance,
  input  logic [IDX_W-1:0] last_idx,
  output logic [N_REQ-1:0] win_onehot,
  output logic [IDX_W-1:0] win_idx,
  output logic             any
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] k;

  always_comb begin
    any        = 1'b0;
    win_idx    = '0;
    win_onehot = '0;
    k          = '0;
    // Scan ptr, ptr+1, ... modulo N_REQ; first requester found wins.
    for (int unsigned i = 0; i < N_REQ; i++) begin
      k = IDX_W'((32'(ptr_q) + i) % N_REQ);
      if (!any && req[k]) begin
        any     = 1'b1;
        win_idx = k;
      end
    end
    if (any) win_onehot[win_idx] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      if (last_idx == IDX_W'(N_REQ - 1)) ptr_d = '0;
      else                               ptr_d = last_idx + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/sqrt_share_scheduler.sv
// Shares one sqrt unit among N_REQ clients: round-robin grant, start pulse,
// watchdog-guarded wait for Done/invalid, then a one-cycle response to the owner.
module sqrt_share_scheduler
  import sqrt_sched_pkg::*;
#(
  parameter  int unsigned N_REQ   = DEF_N_REQ,
  parameter  int unsigned DATA_W  = DEF_DATA_W,
  parameter  int unsigned RES_W   = DEF_RES_W,
  parameter  int unsigned TIMEOUT = 255,
  localparam int unsigned IDX_W   = $clog2(N_REQ)
) (
  input  logic                    clock,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        grant,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [RES_W-1:0]        rsp_result,
  output logic                    rsp_invalid,
  output logic                    rsp_err,
  output logic                    busy,
  output logic                    sq_start,
  output logic [DATA_W-1:0]       sq_operand,
  output logic                    sq_rst,
  input  logic                    sq_done,
  input  logic                    sq_invalid,
  input  logic [RES_W-1:0]        sq_result
);

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [N_REQ-1:0]    owner_oh_q, owner_oh_d;
  logic [DATA_W-1:0]   operand_q, operand_d;
  logic [RES_W-1:0]    res_q, res_d;
  logic                inv_q, inv_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    wd_cnt_q, wd_cnt_d;

  logic [N_REQ-1:0]    win_onehot;
  logic [IDX_W-1:0]    win_idx;
  logic                win_any;
  logic [DATA_W-1:0]   win_operand;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clock      (clock),
    .rst        (rst),
    .req        (req),
    .advance    (state_q == RESP),
    .last_idx   (owner_q),
    .win_onehot (win_onehot),
    .win_idx    (win_idx),
    .any        (win_any)
  );

  always_comb begin
    win_operand = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (win_idx == IDX_W'(i)) win_operand = req_data[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    owner_oh_d = owner_oh_q;
    operand_d  = operand_q;
    res_d      = res_q;
    inv_d      = inv_q;
    err_d      = err_q;
    wd_cnt_d   = wd_cnt_q;
    case (state_q)
      IDLE: begin
        if (win_any) begin
          state_d    = START;
          owner_d    = win_idx;
          owner_oh_d = win_onehot;
          operand_d  = win_operand;
          res_d      = '0;
          inv_d      = 1'b0;
          err_d      = 1'b0;
        end
      end
      START: state_d = WAIT;
      WAIT: begin
        wd_cnt_d = wd_cnt_q + 1'b1;
        // Completion outranks the watchdog; invalid outranks done.
        if (sq_invalid) begin
          inv_d   = 1'b1;
          res_d   = '0;
          state_d = RESP;
        end else if (sq_done) begin
          res_d   = sq_result;
          state_d = RESP;
        end else if (wd_cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = ABORT;
        end
      end
      ABORT: begin
        err_d   = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        wd_cnt_d = '0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      owner_oh_q <= '0;
      operand_q  <= '0;
      res_q      <= '0;
      inv_q      <= 1'b0;
      err_q      <= 1'b0;
      wd_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      owner_oh_q <= owner_oh_d;
      operand_q  <= operand_d;
      res_q      <= res_d;
      inv_q      <= inv_d;
      err_q      <= err_d;
      wd_cnt_q   <= wd_cnt_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign grant       = busy ? owner_oh_q : '0;
  assign sq_start    = (state_q == START);
  assign sq_rst      = (state_q == ABORT);
  assign sq_operand  = operand_q;
  assign rsp_valid   = (state_q == RESP) ? owner_oh_q : '0;
  assign rsp_result  = (state_q == RESP) ? res_q : '0;
  assign rsp_invalid = (state_q == RESP) && inv_q;
  assign rsp_err     = (state_q == RESP) && err_q;

endmodule
